// File: rtl/cookie_collector_if.sv
`default_nettype none
// ============================================================================
// Module      : cookie_collector_if
// Description : Bundle of the sampling, control and word-handshake signals of
//               the cookie random-bit collector. The slave modport is the
//               collector itself; the master modport is whatever drives the
//               raw stream and consumes the assembled words.
// Revision    : 1.0 - initial release
// ============================================================================
interface cookie_collector_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             rbit;
  logic             clr;
  logic             ready_i;
  logic [WIDTH-1:0] word_o;
  logic             valid_o;
  logic             stuck_o;
  logic             overflow_o;

  modport master (
    output en, rbit, clr, ready_i,
    input  word_o, valid_o, stuck_o, overflow_o
  );

  modport slave (
    input  en, rbit, clr, ready_i,
    output word_o, valid_o, stuck_o, overflow_o
  );
endinterface
`default_nettype wire

// File: rtl/cookie_collector.sv
`default_nettype none
// ============================================================================
// Module      : cookie_collector
// Description : Consumer end of the cookie random-bit chain. Samples the
//               serial rbit stream, assembles WIDTH-bit words, offers them
//               through a valid/ready handshake, runs a repetition-count
//               health test on the raw samples and flags dropped words.
//               Optional von Neumann debiasing of the raw stream is enabled
//               by defining the macro COOKIE_VN_DEBIAS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cookie_collector #(
  parameter int WIDTH     = 8,
  parameter int REP_LIMIT = 16
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  cookie_collector_if.slave bus
);

  localparam int                   C_CNT_W   = $clog2(WIDTH);
  localparam int                   C_REP_W   = $clog2(REP_LIMIT + 1);
  localparam logic [C_CNT_W-1:0]   C_LAST    = C_CNT_W'(WIDTH - 1);
  localparam logic [C_REP_W-1:0]   C_REP_MAX = C_REP_W'(REP_LIMIT);
  localparam logic [C_REP_W-1:0]   C_REP_ONE = C_REP_W'(1);

  // A raw sample exists only when enabled and not overridden by clr.
  logic w_sample;
  logic w_accept;
  logic w_acc_bit;

  assign w_sample = bus.en & ~bus.clr;

`ifdef COOKIE_VN_DEBIAS_EN
  typedef enum logic [0:0] {
    VN_FIRST  = 1'b0,
    VN_SECOND = 1'b1
  } vn_state_t;

  vn_state_t r_vn_state;
  logic      r_vn_bit;

  // Von Neumann pair tracker: remember the first sample of each raw pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vn_state <= VN_FIRST;
      r_vn_bit   <= 1'b0;
    end else if (bus.clr) begin
      r_vn_state <= VN_FIRST;
      r_vn_bit   <= 1'b0;
    end else if (bus.en) begin
      case (r_vn_state)
        VN_FIRST: begin
          r_vn_bit   <= bus.rbit;
          r_vn_state <= VN_SECOND;
        end
        default: begin
          r_vn_state <= VN_FIRST;
        end
      endcase
    end
  end

  // A differing pair yields its first bit; equal pairs yield nothing.
  assign w_accept  = w_sample && (r_vn_state == VN_SECOND) && (r_vn_bit != bus.rbit);
  assign w_acc_bit = r_vn_bit;
`else
  assign w_accept  = w_sample;
  assign w_acc_bit = bus.rbit;
`endif

  // ---------------------------------------------------------------------------
  // Word assembly: only WIDTH-1 bits need storing, the last bit arrives live.
  // ---------------------------------------------------------------------------
  logic [WIDTH-2:0]   r_shift;
  logic [C_CNT_W-1:0] r_bit_cnt;
  logic [WIDTH-1:0]   w_word;
  logic               w_complete;

  assign w_word     = {r_shift, w_acc_bit};
  assign w_complete = w_accept && (r_bit_cnt == C_LAST);

  // Shift accepted bits in at the LSB and count them towards a full word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (bus.clr) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_accept) begin
      r_shift   <= w_word[WIDTH-2:0];
      r_bit_cnt <= (r_bit_cnt == C_LAST) ? '0 : r_bit_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Repetition-count health test on raw samples (independent of debiasing).
  // ---------------------------------------------------------------------------
  logic               r_prev_bit;
  logic               r_have_prev;
  logic [C_REP_W-1:0] r_rep_cnt;
  logic [C_REP_W-1:0] w_rep_next;
  logic               r_stuck;

  // Next run length: restart at 1 on a new value or the first sample.
  always_comb begin
    w_rep_next = C_REP_ONE;
    if (r_have_prev && (bus.rbit == r_prev_bit)) begin
      w_rep_next = (r_rep_cnt == C_REP_MAX) ? r_rep_cnt : r_rep_cnt + 1'b1;
    end
  end

  // Track the raw run length and latch the sticky stuck flag when it hits the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_bit  <= 1'b0;
      r_have_prev <= 1'b0;
      r_rep_cnt   <= '0;
      r_stuck     <= 1'b0;
    end else if (bus.clr) begin
      r_have_prev <= 1'b0;
      r_rep_cnt   <= '0;
      r_stuck     <= 1'b0;
    end else if (bus.en) begin
      r_prev_bit  <= bus.rbit;
      r_have_prev <= 1'b1;
      r_rep_cnt   <= w_rep_next;
      if (w_rep_next == C_REP_MAX) begin
        r_stuck <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output holding register and handshake. A stuck source discards completed
  // words silently; a held word is never overwritten, the new one is dropped.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] r_word;
  logic             r_valid;
  logic             r_overflow;
  logic             w_deliver;
  logic             w_room;

  assign w_deliver = w_complete && !r_stuck;
  assign w_room    = !r_valid || bus.ready_i;

  // Load completed words when there is room, drop valid after a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word  <= '0;
      r_valid <= 1'b0;
    end else if (w_deliver && w_room) begin
      r_word  <= w_word;
      r_valid <= 1'b1;
    end else if (r_valid && bus.ready_i) begin
      r_valid <= 1'b0;
    end
  end

  // Sticky overflow: set when a deliverable word finds the register occupied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (bus.clr) begin
      r_overflow <= 1'b0;
    end else if (w_deliver && !w_room) begin
      r_overflow <= 1'b1;
    end
  end

  assign bus.word_o     = r_word;
  assign bus.valid_o    = r_valid;
  assign bus.stuck_o    = r_stuck;
  assign bus.overflow_o = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_cookie_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_cookie_collector
// Description : Self-checking bench for cookie_collector. A reference model
//               pushes expected words into a queue at the edge they complete;
//               a negedge monitor pops one per handshake transfer and also
//               compares valid/stuck/overflow against the model every cycle.
//               Directed scenarios are followed by a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cookie_collector;

  localparam int WIDTH     = 8;
  localparam int REP_LIMIT = 16;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cookie_collector_if #(.WIDTH(WIDTH)) bus ();

  cookie_collector #(
    .WIDTH     (WIDTH),
    .REP_LIMIT (REP_LIMIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: run length as an unbounded integer, word built by plain
  // arithmetic, output buffer occupancy as a count.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] exp_q[$];
  int          m_run, m_nbits, m_occ;
  int unsigned m_acc;
  bit          m_prev, m_have_prev, m_stuck, m_overflow;
  bit          m_vn_have, m_vn_first;

  always @(posedge clk or negedge rst_n) begin
    bit old_stuck;
    bit got;
    bit b;
    if (!rst_n) begin
      exp_q.delete();
      m_run = 0; m_nbits = 0; m_occ = 0; m_acc = 0;
      m_prev = 0; m_have_prev = 0; m_stuck = 0; m_overflow = 0;
      m_vn_have = 0; m_vn_first = 0;
    end else begin
      old_stuck = m_stuck;
      if (m_occ == 1 && bus.ready_i) m_occ = 0;
      if (bus.clr) begin
        m_run = 0; m_nbits = 0; m_acc = 0; m_have_prev = 0;
        m_stuck = 0; m_overflow = 0; m_vn_have = 0;
      end else if (bus.en) begin
        if (m_have_prev && bus.rbit == m_prev) m_run++;
        else m_run = 1;
        m_prev = bus.rbit;
        m_have_prev = 1;
        got = 0;
        b = 0;
`ifdef COOKIE_VN_DEBIAS_EN
        if (!m_vn_have) begin
          m_vn_first = bus.rbit;
          m_vn_have = 1;
        end else begin
          m_vn_have = 0;
          if (m_vn_first != bus.rbit) begin
            got = 1;
            b = m_vn_first;
          end
        end
`else
        got = 1;
        b = bus.rbit;
`endif
        if (got) begin
          m_acc = ((m_acc << 1) | 32'(b)) & ((32'd1 << WIDTH) - 1);
          m_nbits++;
          if (m_nbits == WIDTH) begin
            m_nbits = 0;
            if (!old_stuck) begin
              if (m_occ == 0) begin
                exp_q.push_back(m_acc[WIDTH-1:0]);
                m_occ = 1;
              end else begin
                m_overflow = 1;
              end
            end
          end
        end
        if (m_run >= REP_LIMIT) m_stuck = 1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Monitor: mid-cycle, pop the expected word for every transfer.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] last_word = '0;
  logic [WIDTH-1:0] exp_word;

  always @(negedge clk) begin
    if (rst_n) begin
      check("valid_o", 32'(bus.valid_o), 32'(m_occ == 1));
      check("stuck_o", 32'(bus.stuck_o), 32'(m_stuck));
      check("overflow_o", 32'(bus.overflow_o), 32'(m_overflow));
      if (bus.valid_o && bus.ready_i) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL word_unexpected: actual=%0h required=none at %0t", bus.word_o, $time);
        end else begin
          exp_word = exp_q.pop_front();
          check("word_o", 32'(bus.word_o), 32'(exp_word));
        end
        last_word = bus.word_o;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic step(input bit e, input bit b, input bit c, input bit r);
    bus.en = e; bus.rbit = b; bus.clr = c; bus.ready_i = r;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v, input bit r);
    logic [7:0] t;
    t = v;
    for (int i = 7; i >= 0; i--) step(1'b1, t[i], 1'b0, r);
  endtask

  initial begin
    bit rb;
    int mode;
    rst_n = 1'b0;
    bus.en = 0; bus.rbit = 0; bus.clr = 0; bus.ready_i = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset word_o", 32'(bus.word_o), 32'h0);
    check("reset valid_o", 32'(bus.valid_o), 32'h0);
    check("reset stuck_o", 32'(bus.stuck_o), 32'h0);
    check("reset overflow_o", 32'(bus.overflow_o), 32'h0);
    rst_n = 1'b1;
    step(0, 0, 0, 1);

    // Plain word 0xB2 with ready held high.
    send_byte(8'hB2, 1'b1);
`ifndef COOKIE_VN_DEBIAS_EN
    check("plain valid", 32'(bus.valid_o), 32'h1);
    check("plain word", 32'(bus.word_o), 32'hB2);
`endif
    step(0, 0, 0, 1);
    check("plain valid one cycle", 32'(bus.valid_o), 32'h0);

    // Same word with a three-cycle enable gap after bit 4.
    step(1, 1, 0, 1); step(1, 0, 0, 1); step(1, 1, 0, 1); step(1, 1, 0, 1);
    step(0, 0, 0, 1); step(0, 1, 0, 1); step(0, 0, 0, 1);
    step(1, 0, 0, 1); step(1, 0, 0, 1); step(1, 1, 0, 1); step(1, 0, 0, 1);
`ifndef COOKIE_VN_DEBIAS_EN
    check("gap valid", 32'(bus.valid_o), 32'h1);
    check("gap word", 32'(bus.word_o), 32'hB2);
`endif
    step(0, 0, 0, 1);
    check("gap drained", 32'(bus.valid_o), 32'h0);

    // Backpressure: second word dropped, first held.
    send_byte(8'hA5, 1'b0);
    send_byte(8'h3C, 1'b0);
`ifndef COOKIE_VN_DEBIAS_EN
    check("bp overflow", 32'(bus.overflow_o), 32'h1);
    check("bp word held", 32'(bus.word_o), 32'hA5);
`endif
    step(0, 0, 0, 1);
    check("bp drained", 32'(bus.valid_o), 32'h0);
`ifndef COOKIE_VN_DEBIAS_EN
    check("bp transferred", 32'(last_word), 32'hA5);
`endif
    step(0, 0, 1, 1);
    check("clr overflow", 32'(bus.overflow_o), 32'h0);

    // Stuck source: 16 ones trip the test, later words are discarded.
    for (int i = 0; i < 16; i++) step(1, 1, 0, 1);
    check("stuck set", 32'(bus.stuck_o), 32'h1);
    for (int i = 0; i < 8; i++) step(1, 1'(i % 2), 0, 1);
    check("stuck discards", 32'(bus.valid_o), 32'h0);
    check("stuck sticky", 32'(bus.stuck_o), 32'h1);
    step(0, 0, 1, 1);
    check("clr stuck", 32'(bus.stuck_o), 32'h0);
    send_byte(8'h69, 1'b1);
`ifndef COOKIE_VN_DEBIAS_EN
    check("post clr word", 32'(bus.word_o), 32'h69);
`endif

    // Reset mid-word with a word still held.
    for (int i = 0; i < 5; i++) step(1, 1'(i % 2 == 0), 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst word_o", 32'(bus.word_o), 32'h0);
    check("async rst valid_o", 32'(bus.valid_o), 32'h0);
    check("async rst stuck_o", 32'(bus.stuck_o), 32'h0);
    check("async rst overflow_o", 32'(bus.overflow_o), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_byte(8'h0F, 1'b1);
`ifndef COOKIE_VN_DEBIAS_EN
    check("after rst word", 32'(bus.word_o), 32'h0F);
`endif
    step(0, 0, 0, 1);

    // Raw pairs 01,10,00,11 repeated four times.
    step(0, 0, 1, 1);
    for (int g = 0; g < 4; g++) begin
      step(1, 0, 0, 1); step(1, 1, 0, 1);
      step(1, 1, 0, 1); step(1, 0, 0, 1);
      step(1, 0, 0, 1); step(1, 0, 0, 1);
      step(1, 1, 0, 1); step(1, 1, 0, 1);
    end
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
`ifdef COOKIE_VN_DEBIAS_EN
    check("debias word", 32'(last_word), 32'h55);
`endif

    // Randomized phase: bursty enables, backpressure, long runs, rare clr.
    rb = 0;
    mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) mode = int'($urandom_range(0, 2));
      if (mode == 0) rb = 1'($urandom);
      else if ($urandom_range(0, 40) == 0) rb = ~rb;
      step(1'($urandom_range(0, 3) != 0), rb,
           1'($urandom_range(0, 199) == 0),
           1'($urandom_range(0, 2) != 0));
    end

    repeat (4) step(0, 0, 0, 1);
    check("queue empty", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
